uart_axis_fifo: RTL and testbench



---
 rtl/uart_axis_fifo.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_uart_axis_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axis_fifo.sv
// Full-duplex UART bridging AXI-Stream byte streams, with a FWFT FIFO on each direction.
// Optional parity frame bit enabled by defining UART_AXIS_PARITY_EN.
//
// state    | meaning
// IDLE     | line idle; RX waits for a low level, TX waits for a queued character
// START    | RX qualifies the start bit at its centre; TX drives the start bit
// DATA     | DATA_WIDTH bits, LSB first, one bit per DIVIDER cycles
// PARITY   | parity bit (only with UART_AXIS_PARITY_EN)
// STOP     | RX samples the first stop bit and pushes; TX holds STOP_BITS stop bits
module uart_axis_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER       = 100,
  parameter int DIVIDER_WIDTH = 7,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0,
  parameter int FIFO_AW       = 4
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [DATA_WIDTH-1:0] s_data_tdata,
  input  logic                  s_data_tvalid,
  output logic                  s_data_tready,
  output logic [DATA_WIDTH-1:0] m_data_tdata,
  output logic [1:0]            m_data_tuser,
  output logic                  m_data_tvalid,
  input  logic                  m_data_tready,
  output logic                  rx_overrun,
  output logic [FIFO_AW:0]      tx_level,
  output logic [FIFO_AW:0]      rx_level,
  input  logic                  rx,
  output logic                  tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int RXW   = DATA_WIDTH + 2;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIVIDER_WIDTH-1:0] CNT_LAST  = DIVIDER_WIDTH'(DIVIDER - 1);
  localparam logic [DIVIDER_WIDTH-1:0] CNT_HALF  = DIVIDER_WIDTH'(DIVIDER / 2 - 1);
  localparam logic [BIT_W-1:0]         BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic                     STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0]         LVL_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_AXIS_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } uart_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [FIFO_AW:0]      tx_wr_ptr, tx_rd_ptr;
  logic                  tx_full, tx_empty, tx_push, tx_pop, ready_en;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_level      = tx_wr_ptr - tx_rd_ptr;
  assign tx_full       = (tx_level == LVL_FULL);
  assign tx_empty      = (tx_level == '0);
  assign s_data_tready = ready_en & ~tx_full;
  assign tx_push       = s_data_tvalid & s_data_tready;
  assign tx_head       = tx_mem[tx_rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      ready_en  <= 1'b0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      ready_en <= 1'b1;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= s_data_tdata;
  end

  // ---------------- TX FSM ----------------
  uart_state_t              tx_state, tx_next;
  logic [DIVIDER_WIDTH-1:0] tx_cnt;
  logic [BIT_W-1:0]         tx_bit_idx;
  logic                     tx_stop_idx;
  logic [DATA_WIDTH-1:0]    tx_shift;
  logic                     tx_tick, tx_bit;
`ifdef UART_AXIS_PARITY_EN
  logic                     tx_par;
`endif

  assign tx_tick = (tx_cnt == CNT_LAST);

  always_ff @(posedge aclk) begin
    if (!arstn) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    tx_bit  = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_next = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_bit = tx_shift[0];
        if (tx_tick && tx_bit_idx == BIT_LAST)
`ifdef UART_AXIS_PARITY_EN
          tx_next = S_PARITY;
`else
          tx_next = S_STOP;
`endif
      end
`ifdef UART_AXIS_PARITY_EN
      S_PARITY: begin
        tx_bit = tx_par;
        if (tx_tick) tx_next = S_STOP;
      end
`endif
      S_STOP: begin
        // a queued character starts right after the last stop bit, no idle cycle
        if (tx_tick && tx_stop_idx == STOP_LAST) begin
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_next = S_START;
          end else begin
            tx_next = S_IDLE;
          end
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      tx          <= 1'b1;
      tx_cnt      <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
    end else begin
      tx <= tx_bit;
      if (tx_pop) begin
        tx_shift    <= tx_head;
        tx_cnt      <= '0;
        tx_bit_idx  <= '0;
        tx_stop_idx <= 1'b0;
      end else if (tx_state != S_IDLE) begin
        tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
        if (tx_tick && tx_state == S_DATA) begin
          tx_shift   <= tx_shift >> 1;
          tx_bit_idx <= tx_bit_idx + 1'b1;
        end
        if (tx_tick && tx_state == S_STOP) tx_stop_idx <= tx_stop_idx + 1'b1;
      end
    end
  end

`ifdef UART_AXIS_PARITY_EN
  always_ff @(posedge aclk) begin
    if (!arstn)      tx_par <= 1'b0;
    else if (tx_pop) tx_par <= (^tx_head) ^ 1'(PARITY_ODD);
  end
`endif

  // ---------------- RX synchroniser + FSM ----------------
  logic                     rx_meta, rx_sync;
  uart_state_t              rx_state, rx_next;
  logic [DIVIDER_WIDTH-1:0] rx_cnt;
  logic [BIT_W-1:0]         rx_bit_idx;
  logic [DATA_WIDTH-1:0]    rx_shift;
  logic                     rx_tick, rx_push_req, rx_par_err;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_tick = (rx_cnt == CNT_LAST);

  always_ff @(posedge aclk) begin
    if (!arstn) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    rx_push_req = 1'b0;
    case (rx_state)
      S_IDLE:  if (!rx_sync) rx_next = S_START;
      // a start bit that is high again at its centre was a glitch
      S_START: if (rx_cnt == CNT_HALF) rx_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA: begin
        if (rx_tick && rx_bit_idx == BIT_LAST)
`ifdef UART_AXIS_PARITY_EN
          rx_next = S_PARITY;
`else
          rx_next = S_STOP;
`endif
      end
`ifdef UART_AXIS_PARITY_EN
      S_PARITY: if (rx_tick) rx_next = S_STOP;
`endif
      S_STOP: begin
        if (rx_tick) begin
          rx_push_req = 1'b1;
          rx_next     = S_IDLE;
        end
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_cnt     <= '0;
          rx_bit_idx <= '0;
        end
        S_START: rx_cnt <= (rx_cnt == CNT_HALF) ? '0 : rx_cnt + 1'b1;
        default: begin
          rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
          if (rx_tick && rx_state == S_DATA) begin
            rx_shift   <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
            rx_bit_idx <= rx_bit_idx + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UART_AXIS_PARITY_EN
  always_ff @(posedge aclk) begin
    if (!arstn)
      rx_par_err <= 1'b0;
    else if (rx_state == S_PARITY && rx_tick)
      rx_par_err <= rx_sync ^ (^rx_shift) ^ 1'(PARITY_ODD);
  end
`else
  assign rx_par_err = 1'b0;
`endif

  // ---------------- RX FIFO ----------------
  logic [RXW-1:0]   rx_mem [DEPTH];
  logic [FIFO_AW:0] rx_wr_ptr, rx_rd_ptr;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [RXW-1:0]   rx_head;

  assign rx_level      = rx_wr_ptr - rx_rd_ptr;
  assign rx_full       = (rx_level == LVL_FULL);
  assign rx_empty      = (rx_level == '0);
  assign m_data_tvalid = ~rx_empty;
  assign rx_pop        = m_data_tvalid & m_data_tready;
  assign rx_push       = rx_push_req & (~rx_full | rx_pop);
  assign rx_head       = rx_mem[rx_rd_ptr[FIFO_AW-1:0]];
  assign {m_data_tuser, m_data_tdata} = rx_empty ? '0 : rx_head;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_push_req & rx_full & ~rx_pop;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (rx_push) rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= {rx_par_err, ~rx_sync, rx_shift};
  end

endmodule

// File: tb/tb_uart_axis_fifo.sv
// Bench for uart_axis_fifo at DIVIDER=16, 8N1 (parity cases when UART_AXIS_PARITY_EN is defined).
// All activity runs in one process; tick() advances to the next falling edge.
module tb_uart_axis_fifo;
  localparam int DW  = 8;
  localparam int DIV = 16;
  localparam int AW  = 4;

  logic          aclk = 1'b0;
  logic          arstn = 1'b0;
  logic [DW-1:0] s_data_tdata = '0;
  logic          s_data_tvalid = 1'b0;
  logic          s_data_tready;
  logic [DW-1:0] m_data_tdata;
  logic [1:0]    m_data_tuser;
  logic          m_data_tvalid;
  logic          m_data_tready;
  logic          rx_overrun;
  logic [AW:0]   tx_level, rx_level;
  logic          rx, tx;

  logic loop_en = 1'b0;
  logic rx_bit  = 1'b1;
  logic sink_en = 1'b0;
  assign rx = loop_en ? tx : rx_bit;
  assign m_data_tready = sink_en;

  uart_axis_fifo #(
    .DATA_WIDTH(DW), .DIVIDER(DIV), .DIVIDER_WIDTH(4),
    .STOP_BITS(1), .PARITY_ODD(0), .FIFO_AW(AW)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .m_data_tdata(m_data_tdata), .m_data_tuser(m_data_tuser),
    .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
    .rx_overrun(rx_overrun), .tx_level(tx_level), .rx_level(rx_level),
    .rx(rx), .tx(tx)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [7:0] data; logic [1:0] user;} exp_t;
  typedef struct {logic [7:0] din; logic [7:0] exp_data; logic [1:0] exp_user;} vec_t;

  exp_t sb[$];
  vec_t vec[17];
  int total = 0;
  int bad = 0;
  int ovr_cnt = 0;
  int peak = 0;
  int full_ready = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consume the RX head if it will be handshaken on the coming rising edge.
  task automatic tick();
    exp_t e;
    if (sink_en && m_data_tvalid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %0h (user %0h) with nothing expected", m_data_tdata, m_data_tuser);
      end else begin
        e = sb.pop_front();
        check("rx_data", m_data_tdata, e.data);
        check("rx_user", m_data_tuser, e.user);
      end
    end
    @(negedge aclk);
    if (rx_overrun) ovr_cnt++;
    if (int'(tx_level) > peak) peak = int'(tx_level);
    if (tx_level == 5'd16 && s_data_tready) full_ready++;
  endtask

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    s_data_tvalid = 1'b1;
    s_data_tdata  = d;
    while (!s_data_tready && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      total++;
      bad++;
      $display("FAIL tx_write_timeout: ready stayed %0b for %0d cycles, expected 1", s_data_tready, n);
    end
    tick();
    s_data_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    rx_bit = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < DW; i++) begin
      rx_bit = d[i];
      repeat (DIV) tick();
    end
`ifdef UART_AXIS_PARITY_EN
    rx_bit = par_v;
    repeat (DIV) tick();
`else
    if (par_v) rx_bit = 1'b1;
`endif
    rx_bit = stop_v;
    repeat (DIV) tick();
    rx_bit = 1'b1;
    repeat (DIV) tick();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  // Expected tx level k cycles after the write handshake edge, for an 8N1 frame.
  function automatic logic exp_tx(input int k, input logic [7:0] d);
    if (k < 2)   return 1'b1;
    if (k < 18)  return 1'b0;
    if (k < 146) return d[(k - 18) / DIV];
    return 1'b1;
  endfunction

  initial begin
    int ovr_base;
    int n;

    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_tready", s_data_tready, 0);
    check("rst_tvalid", m_data_tvalid, 0);
    check("rst_tdata", m_data_tdata, 0);
    check("rst_tuser", m_data_tuser, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    arstn = 1'b1;
    tick();
    check("ready_after_release", s_data_tready, 1);

    // single 0xA5 frame on the tx line, cycle by cycle
    s_data_tvalid = 1'b1;
    s_data_tdata  = 8'hA5;
    tick();
    s_data_tvalid = 1'b0;
    check("tx_level_after_write", tx_level, 1);
    for (int k = 1; k <= 165; k++) begin
      tick();
      check($sformatf("tx_wave_k%0d", k), tx, exp_tx(k, 8'hA5));
    end

    // loopback burst, table driven
    for (int i = 0; i < 17; i++) begin
      vec[i].din      = 8'(i);
      vec[i].exp_data = 8'(i);
      vec[i].exp_user = 2'b00;
    end
    loop_en = 1'b1;
    sink_en = 1'b1;
    peak = 0;
    full_ready = 0;
    ovr_base = ovr_cnt;
    for (int i = 0; i < 17; i++) begin
      sb.push_back('{data: vec[i].exp_data, user: vec[i].exp_user});
      write_tx(vec[i].din);
    end
    wait_drain("burst_drain", 4000);
    check("burst_peak_level", peak, 16);
    check("burst_ready_while_full", full_ready, 0);
    check("burst_no_overrun", ovr_cnt - ovr_base, 0);

    // overrun: 17 characters into a 16-deep RX FIFO with no reader
    sink_en = 1'b0;
    ovr_base = ovr_cnt;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back('{data: 8'(8'h40 + i), user: 2'b00});
      write_tx(8'(8'h40 + i));
    end
    n = 0;
    while (tx_level != '0 && n < 4000) begin
      tick();
      n++;
    end
    check("ovr_tx_emptied", tx_level, 0);
    repeat (250) tick();
    check("ovr_rx_level", rx_level, 16);
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    check("ovr_first_read", m_data_tdata, 8'h40);
    sink_en = 1'b1;
    wait_drain("ovr_drain", 200);
    repeat (20) tick();
    check("ovr_17th_lost", rx_level, 0);
    loop_en = 1'b0;

    // glitch shorter than half a bit, then a real 0x3C
    rx_bit = 1'b0;
    repeat (5) tick();
    rx_bit = 1'b1;
    repeat (40) tick();
    check("glitch_no_char", rx_level, 0);
    sb.push_back('{data: 8'h3C, user: 2'b00});
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_drain("glitch_then_3c", 100);

    // stop bit driven low
    sb.push_back('{data: 8'h55, user: 2'b01});
    send_frame(8'h55, 1'b0, 1'b0);
    wait_drain("frame_err", 100);
    repeat (60) tick();
    check("frame_err_no_extra", rx_level, 0);

`ifdef UART_AXIS_PARITY_EN
    sb.push_back('{data: 8'h07, user: 2'b00});
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("parity_ok", 100);
    sb.push_back('{data: 8'h07, user: 2'b10});
    send_frame(8'h07, 1'b1, 1'b0);
    wait_drain("parity_bad", 100);
`endif

    // reset in the middle of a TX frame
    write_tx(8'h81);
    write_tx(8'h18);
    repeat (49) tick();
`ifdef UART_AXIS_PARITY_EN
    check("mid_frame_tx", tx, 1'b0);
`else
    check("mid_frame_tx", tx, exp_tx(50, 8'h81));
`endif
    arstn = 1'b0;
    tick();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_tx_level", tx_level, 0);
    check("mid_rst_rx_level", rx_level, 0);
    check("mid_rst_tready", s_data_tready, 0);
    arstn = 1'b1;
    repeat (200) tick();
    check("post_rst_tx_idle", tx, 1);
    check("post_rst_tx_level", tx_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end
endmodule
